// File: rtl/spi_master_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// spi_arb_pkg
//   Shared definitions for the SPI master arbiter slice: operation encodings,
//   arbiter FSM states, data/wait widths and small op decode helpers.
// ----------------------------------------------------------------------------
package spi_arb_pkg;

  localparam int DATA_W = 12;
  localparam int WAIT_W = 8;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_TX   = 2'b01;
  localparam logic [1:0] OP_RX   = 2'b10;
  localparam logic [1:0] OP_FD   = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4
  } arb_state_e;

  // Whether an op expects the master's transmit-complete pulse.
  function automatic logic op_needs_tx(input logic [1:0] op);
    return (op == OP_TX) || (op == OP_FD);
  endfunction

  // Whether an op expects the master's receive-complete pulse.
  function automatic logic op_needs_rx(input logic [1:0] op);
    return (op == OP_RX) || (op == OP_FD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search starts one past the last
//   granted index and wraps, so the most recent winner has lowest priority.
//
//   eligible  in  NUM_REQ  requesters that may be granted
//   ptr       in  IDX_W    index of the last granted requester
//   grant     out NUM_REQ  one-hot grant (all zero when nothing eligible)
//   grant_idx out IDX_W    index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    // Offsets 1..NUM_REQ visit every requester once, ending on ptr itself.
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// ----------------------------------------------------------------------------
// spi_master_arbiter
//   Shares one spi_master among NUM_REQ requesters. Grants one request at a
//   time in round-robin order, issues a one-cycle req to the master, waits for
//   chip select to fall (with a start timeout), collects the completion
//   pulses the op requires, then returns data and a done pulse.
//
//   clk, rst            clock; asynchronous active-high reset
//   rq_valid/op/din/wait per-requester request inputs (packed per index)
//   rq_ack              one-hot pulse: request accepted and latched
//   rq_done             one-hot pulse: transaction finished
//   rq_err              with rq_done: start timeout, no transfer happened
//   rq_dout             received word, updated on RX/FD completion only
//   busy                high from ack through done
//   m_req/m_din/m_wait  master request inputs
//   m_dout/m_cs/m_done_tx/m_done_rx  master status inputs
// ----------------------------------------------------------------------------
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        rq_valid,
  input  logic [2*NUM_REQ-1:0]      rq_op,
  input  logic [DATA_W*NUM_REQ-1:0] rq_din,
  input  logic [WAIT_W*NUM_REQ-1:0] rq_wait,
  output logic [NUM_REQ-1:0]        rq_ack,
  output logic [NUM_REQ-1:0]        rq_done,
  output logic                      rq_err,
  output logic [DATA_W-1:0]         rq_dout,
  output logic                      busy,
  output logic [1:0]                m_req,
  output logic [DATA_W-1:0]         m_din,
  output logic [WAIT_W-1:0]         m_wait,
  input  logic [DATA_W-1:0]         m_dout,
  input  logic                      m_cs,
  input  logic                      m_done_tx,
  input  logic                      m_done_rx
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                busy_q, busy_d;
  logic [1:0]          m_req_q, m_req_d;
  logic                seen_tx_q, seen_tx_d;
  logic                seen_rx_q, seen_rx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [IDX_W-1:0]    grant_idx;
  logic                any_grant;
  logic [1:0]          sel_op;
  logic [DATA_W-1:0]   sel_din;
  logic [WAIT_W-1:0]   sel_wait;
  logic                tx_ok;
  logic                rx_ok;

  // Requester eligibility: op 00 never competes.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = rq_valid[i] && (rq_op[2*i +: 2] != OP_NONE);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .eligible  (eligible),
    .ptr       (last_grant_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx)
  );

  assign any_grant = |grant_oh;

  // Fields of the requester the arbiter currently picks.
  always_comb begin
    sel_op   = OP_NONE;
    sel_din  = '0;
    sel_wait = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_op   = rq_op[2*i +: 2];
        sel_din  = rq_din[DATA_W*i +: DATA_W];
        sel_wait = rq_wait[WAIT_W*i +: WAIT_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    op_d         = op_q;
    din_d        = din_q;
    wait_d       = wait_q;
    ack_d        = '0;
    done_d       = '0;
    err_d        = 1'b0;
    dout_d       = dout_q;
    busy_d       = busy_q;
    m_req_d      = OP_NONE;
    seen_tx_d    = seen_tx_q;
    seen_rx_d    = seen_rx_q;
    tmo_d        = tmo_q;
    tx_ok        = 1'b0;
    rx_ok        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A grant waits until the master is back idle (cs high).
        if (any_grant && m_cs) begin
          ack_d   = grant_oh;
          gnt_d   = grant_oh;
          sel_d   = grant_idx;
          op_d    = sel_op;
          din_d   = sel_din;
          wait_d  = sel_wait;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // m_req is registered, so it is high for exactly the first START cycle.
        m_req_d   = op_q;
        tmo_d     = '0;
        seen_tx_d = 1'b0;
        seen_rx_d = 1'b0;
        state_d   = START;
      end
      START: begin
        if (!m_cs) begin
          state_d = BUSY;
        end else if (tmo_q == TMO_LAST) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      BUSY: begin
        // Done pulses may come in either order or together; keep them sticky.
        seen_tx_d = seen_tx_q | m_done_tx;
        seen_rx_d = seen_rx_q | m_done_rx;
        tx_ok     = !op_needs_tx(op_q) || seen_tx_d;
        rx_ok     = !op_needs_rx(op_q) || seen_rx_d;
        if (tx_ok && rx_ok) begin
          done_d = gnt_q;
          if (op_needs_rx(op_q)) begin
            dout_d = m_dout;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        // rq_done/rq_err are visible during this state.
        last_grant_d = sel_q;
        busy_d       = 1'b0;
        seen_tx_d    = 1'b0;
        seen_rx_d    = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      sel_q        <= '0;
      gnt_q        <= '0;
      op_q         <= OP_NONE;
      din_q        <= '0;
      wait_q       <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
      m_req_q      <= OP_NONE;
      seen_tx_q    <= 1'b0;
      seen_rx_q    <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      op_q         <= op_d;
      din_q        <= din_d;
      wait_q       <= wait_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      m_req_q      <= m_req_d;
      seen_tx_q    <= seen_tx_d;
      seen_rx_q    <= seen_rx_d;
      tmo_q        <= tmo_d;
    end
  end

  assign rq_ack  = ack_q;
  assign rq_done = done_q;
  assign rq_err  = err_q;
  assign rq_dout = dout_q;
  assign busy    = busy_q;
  assign m_req   = m_req_q;
  assign m_din   = din_q;
  assign m_wait  = wait_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_master_arbiter
//   Directed bench for spi_master_arbiter with a behavioural spi_master stand-in:
//   it registers req, drops cs two cycles after issue, and raises the done
//   pulse(s) stub_len cycles later (optionally tx and rx in separate cycles).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rq_valid;
  logic [7:0]  rq_op;
  logic [47:0] rq_din;
  logic [31:0] rq_wait;
  logic [3:0]  rq_ack;
  logic [3:0]  rq_done;
  logic        rq_err;
  logic [11:0] rq_dout;
  logic        busy;
  logic [1:0]  m_req;
  logic [11:0] m_din;
  logic [7:0]  m_wait;
  logic [11:0] m_dout;
  logic        m_cs;
  logic        m_done_tx;
  logic        m_done_rx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_arbiter #(
    .NUM_REQ       (4),
    .START_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rq_valid  (rq_valid),
    .rq_op     (rq_op),
    .rq_din    (rq_din),
    .rq_wait   (rq_wait),
    .rq_ack    (rq_ack),
    .rq_done   (rq_done),
    .rq_err    (rq_err),
    .rq_dout   (rq_dout),
    .busy      (busy),
    .m_req     (m_req),
    .m_din     (m_din),
    .m_wait    (m_wait),
    .m_dout    (m_dout),
    .m_cs      (m_cs),
    .m_done_tx (m_done_tx),
    .m_done_rx (m_done_rx)
  );

  // Master stand-in controls
  logic        stub_dead;
  logic        stub_split;
  int          stub_len;
  logic [11:0] stub_rdata;
  logic        stray_tx;
  logic        stray_rx;
  int          sc;
  logic [1:0]  sreq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cs      <= 1'b1;
      m_done_tx <= 1'b0;
      m_done_rx <= 1'b0;
      m_dout    <= '0;
      sc        <= 0;
      sreq      <= 2'b00;
    end else begin
      m_done_tx <= stray_tx;
      m_done_rx <= stray_rx;
      if (sc == 0) begin
        if (m_req != 2'b00 && !stub_dead) begin
          sreq <= m_req;
          sc   <= 1;
        end
      end else begin
        sc <= sc + 1;
        if (sc == 1) begin
          m_cs   <= 1'b0;
          m_dout <= stub_rdata;
        end
        if (sc == 1 + stub_len) begin
          if (sreq == 2'b11 && stub_split) begin
            m_done_tx <= 1'b1;
          end else begin
            m_done_tx <= sreq[0];
            m_done_rx <= sreq[1];
            m_cs      <= 1'b1;
            sc        <= 0;
          end
        end
        if (sc == 2 + stub_len) begin
          m_done_rx <= 1'b1;
          m_cs      <= 1'b1;
          sc        <= 0;
        end
      end
    end
  end

  // Event monitor, sampled mid-cycle
  int   cyc = 0;
  int   done_total = 0;
  int   mreq_cycles = 0;
  int   overlap = 0;
  int   ack1_cnt = 0;
  int   issue_cyc = 0;
  int   done_cyc = 0;
  int   mdone_cyc = 0;
  logic open_txn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      open_txn = 1'b0;
    end else begin
      if (rq_ack != 4'b0000) begin
        if (open_txn) overlap++;
        open_txn = 1'b1;
        if (rq_ack[1]) ack1_cnt++;
      end
      if (m_req != 2'b00) begin
        mreq_cycles++;
        issue_cyc = cyc;
      end
      if (rq_done != 4'b0000) begin
        done_total++;
        done_cyc = cyc;
        open_txn = 1'b0;
      end
      if (m_done_tx || m_done_rx) mdone_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [11:0] din,
                         input logic [7:0] w);
    rq_op[2*i +: 2]   = op;
    rq_din[12*i +: 12] = din;
    rq_wait[8*i +: 8]  = w;
  endtask

  // Returns 0 if no ack within the budget, which the caller's check flags.
  task automatic wait_ack(output logic [3:0] got);
    got = 4'b0000;
    for (int n = 0; n < 60; n++) begin
      step();
      if (rq_ack != 4'b0000) begin
        got = rq_ack;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic [3:0] got);
    got = 4'b0000;
    for (int n = 0; n < 60; n++) begin
      step();
      if (rq_done != 4'b0000) begin
        got = rq_done;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] got;
    int d0;
    int m0;
    int a1;

    rst        = 1'b1;
    rq_valid   = 4'b0000;
    rq_op      = '0;
    rq_din     = '0;
    rq_wait    = '0;
    stub_dead  = 1'b0;
    stub_split = 1'b0;
    stub_len   = 2;
    stub_rdata = 12'h000;
    stray_tx   = 1'b0;
    stray_rx   = 1'b0;
    repeat (3) step();

    // Reset values
    chk("rst m_req",   32'(m_req),   0);
    chk("rst m_din",   32'(m_din),   0);
    chk("rst m_wait",  32'(m_wait),  0);
    chk("rst rq_ack",  32'(rq_ack),  0);
    chk("rst rq_done", 32'(rq_done), 0);
    chk("rst rq_err",  32'(rq_err),  0);
    chk("rst rq_dout", 32'(rq_dout), 0);
    chk("rst busy",    32'(busy),    0);
    rst = 1'b0;
    step();
    step();

    // Round robin: all four TX requests held valid
    for (int i = 0; i < 4; i++) set_req(i, 2'b01, 12'(12'h100 + i), 8'd1);
    rq_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(got);
      chk($sformatf("rr ack #%0d", k), 32'(got), 1 << (k % 4));
    end
    rq_valid = 4'b0000;
    wait_done(got);
    chk("rr last done", 32'(got), 'h1);
    step();
    chk("rr busy overlap", 32'(overlap), 0);
    chk("rr m_req cycles", 32'(mreq_cycles), 5);

    // Single TX on requester 0
    m0 = mreq_cycles;
    d0 = done_total;
    stub_len = 3;
    set_req(0, 2'b01, 12'hA5C, 8'd2);
    rq_valid = 4'b0001;
    wait_ack(got);
    chk("tx ack", 32'(got), 'h1);
    rq_valid = 4'b0000;
    chk("tx busy at ack", 32'(busy), 1);
    step();
    chk("tx m_req", 32'(m_req), 'h1);
    chk("tx m_din", 32'(m_din), 'hA5C);
    chk("tx m_wait", 32'(m_wait), 2);
    step();
    chk("tx m_req one shot", 32'(m_req), 0);
    wait_done(got);
    chk("tx done", 32'(got), 'h1);
    chk("tx err", 32'(rq_err), 0);
    chk("tx dout held", 32'(rq_dout), 0);
    step();
    chk("tx done latency", 32'(done_cyc - mdone_cyc), 1);
    chk("tx done count", 32'(done_total - d0), 1);
    chk("tx m_req cycles", 32'(mreq_cycles - m0), 1);
    chk("tx m_din held", 32'(m_din), 'hA5C);
    chk("tx m_wait held", 32'(m_wait), 2);
    chk("tx busy cleared", 32'(busy), 0);

    // Full duplex on requester 2, tx and rx pulses in separate cycles
    stub_len   = 2;
    stub_split = 1'b1;
    stub_rdata = 12'hF0F;
    set_req(2, 2'b11, 12'h3C1, 8'd5);
    rq_valid = 4'b0100;
    wait_ack(got);
    chk("fd ack", 32'(got), 'h4);
    rq_valid = 4'b0000;
    step();
    chk("fd m_req", 32'(m_req), 'h3);
    chk("fd m_din", 32'(m_din), 'h3C1);
    chk("fd m_wait", 32'(m_wait), 5);
    wait_done(got);
    chk("fd done", 32'(got), 'h4);
    chk("fd err", 32'(rq_err), 0);
    chk("fd dout", 32'(rq_dout), 'hF0F);
    step();
    chk("fd done after last pulse", 32'(done_cyc - mdone_cyc), 1);
    stub_split = 1'b0;

    // Start timeout: master never drops cs
    stub_dead = 1'b1;
    set_req(1, 2'b10, 12'h123, 8'd1);
    rq_valid = 4'b0010;
    wait_ack(got);
    chk("tmo ack", 32'(got), 'h2);
    rq_valid = 4'b0000;
    wait_done(got);
    chk("tmo done", 32'(got), 'h2);
    chk("tmo err", 32'(rq_err), 1);
    chk("tmo dout unchanged", 32'(rq_dout), 'hF0F);
    step();
    chk("tmo latency from issue", 32'(done_cyc - issue_cyc), 4);
    chk("tmo err one pulse", 32'(rq_err), 0);
    stub_dead = 1'b0;

    // Op 00 on requester 1 is ineligible; requester 3 RX is served
    stub_rdata = 12'h5A7;
    a1 = ack1_cnt;
    set_req(1, 2'b00, 12'h777, 8'd1);
    set_req(3, 2'b10, 12'h000, 8'd3);
    rq_valid = 4'b1010;
    wait_ack(got);
    chk("op00 rx ack", 32'(got), 'h8);
    rq_valid = 4'b0010;
    wait_done(got);
    chk("op00 rx done", 32'(got), 'h8);
    chk("op00 rx err", 32'(rq_err), 0);
    chk("op00 rx dout", 32'(rq_dout), 'h5A7);
    repeat (10) step();
    chk("op00 never acked", 32'(ack1_cnt - a1), 0);
    rq_valid = 4'b0000;

    // Stray master done pulses while idle
    d0 = done_total;
    stray_tx = 1'b1;
    step();
    stray_tx = 1'b0;
    stray_rx = 1'b1;
    step();
    stray_rx = 1'b0;
    repeat (4) step();
    chk("stray no done", 32'(done_total - d0), 0);
    chk("stray not busy", 32'(busy), 0);

    // Reset while BUSY
    stub_len = 6;
    set_req(2, 2'b01, 12'hBEE, 8'd4);
    rq_valid = 4'b0100;
    wait_ack(got);
    chk("rstb ack", 32'(got), 'h4);
    rq_valid = 4'b0000;
    for (int n = 0; n < 20; n++) begin
      if (!m_cs) break;
      step();
    end
    chk("rstb cs low", 32'(m_cs), 0);
    step();
    step();
    chk("rstb busy before", 32'(busy), 1);
    d0 = done_total;
    rst = 1'b1;
    #1;
    chk("rstb m_req",   32'(m_req),   0);
    chk("rstb m_din",   32'(m_din),   0);
    chk("rstb m_wait",  32'(m_wait),  0);
    chk("rstb rq_ack",  32'(rq_ack),  0);
    chk("rstb rq_done", 32'(rq_done), 0);
    chk("rstb rq_err",  32'(rq_err),  0);
    chk("rstb rq_dout", 32'(rq_dout), 0);
    chk("rstb busy",    32'(busy),    0);
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("rstb no done", 32'(done_total - d0), 0);

    // After reset, requester 0 wins first, then requester 2
    stub_len = 2;
    set_req(0, 2'b01, 12'h0F0, 8'd1);
    rq_valid = 4'b0101;
    wait_ack(got);
    chk("post rst ack 0", 32'(got), 'h1);
    rq_valid = 4'b0100;
    wait_done(got);
    chk("post rst done 0", 32'(got), 'h1);
    chk("post rst err 0", 32'(rq_err), 0);
    wait_ack(got);
    chk("post rst ack 2", 32'(got), 'h4);
    rq_valid = 4'b0000;
    wait_done(got);
    chk("post rst done 2", 32'(got), 'h4);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin scheduler that shares one `spi_master` instance among `NUM_REQ` independent requesters. It accepts per-requester operation requests (transmit, receive, full duplex) and grants one at a time. It drives the master's `req`/`din`/`wait_duration` with correct one-shot timing, tracks completion via `done_tx`/`done_rx`, and returns received data and a completion pulse to the granted requester. It sits between client logic and `spi_master`; the arbiter is the only driver of the master's request inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `START_TIMEOUT`, 4: clk cycles allowed between request issue and `m_cs` going low.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rq_valid`  in  NUM_REQ  per-requester request pending.
- `rq_op`  in  2*NUM_REQ  per-requester op: 01 TX, 10 RX, 11 full duplex; 00 is not eligible.
- `rq_din`  in  12*NUM_REQ  per-requester transmit word.
- `rq_wait`  in  8*NUM_REQ  per-requester wait duration.
- `rq_ack`  out  NUM_REQ  one-hot, one-cycle pulse; request accepted and inputs latched.
- `rq_done`  out  NUM_REQ  one-hot, one-cycle pulse; transaction finished.
- `rq_err`  out  1  valid with `rq_done`; 1 means start timeout, no transfer.
- `rq_dout`  out  12  received word, valid with `rq_done`, held until the next `rq_done`.
- `busy`  out  1  high from ack through done.
- `m_req`  out  2  to `spi_master.req`.
- `m_din`  out  12  to `spi_master.din`.
- `m_wait`  out  8  to `spi_master.wait_duration`.
- `m_dout`  in  12  from `spi_master.dout`.
- `m_cs`  in  1  from `spi_master.cs`, active-low.
- `m_done_tx`, `m_done_rx`  in  1 each  from master completion pulses.

## Operation
- Eligible requester i: `rq_valid[i]` and `rq_op[i] != 00`.
- Round-robin: the search starts at `last_grant+1` mod NUM_REQ. `last_grant` resets to NUM_REQ-1, so requester 0 wins first.
- FSM states:
  - IDLE: if any requester is eligible and `m_cs`=1, latch that requester's op/din/wait, pulse `rq_ack[i]`, set `busy`, and go to ISSUE.
  - ISSUE: drive `m_req`=op for exactly one cycle, then go to START.
  - START: `m_req`=00. If `m_cs`=0, go to BUSY. If the timeout counter reaches `START_TIMEOUT`, go to DONE with err=1.
  - BUSY: set sticky flags `seen_tx`/`seen_rx` on the done pulses. Required set: 01→tx, 10→rx, 11→both, which may arrive in either order or in the same cycle. When the set is complete, go to DONE.
  - DONE: capture `m_dout` into `rq_dout` only for RX/FD ops without error; otherwise `rq_dout` is held. Pulse `rq_done[i]` and `rq_err`, update `last_grant`=i, clear `busy`, and go to IDLE.
- `m_din` and `m_wait` hold the latched values from ISSUE until the next grant.
- A requester must keep its inputs stable while `rq_valid` is high and not yet acked. It may re-assert `rq_valid` immediately after ack; that request is queued for the next round.
- `rq_valid` dropped before ack: the request is withdrawn and no ack is given.
- Stray `m_done_*` pulses outside BUSY are ignored.

## Timing
- Reset values: `m_req`=00, `m_din`=0, `m_wait`=0, `rq_ack`=0, `rq_done`=0, `rq_err`=0, `rq_dout`=0, `busy`=0, state IDLE, flags cleared.
- Ack is registered: the cycle after eligibility is seen in IDLE. `m_req` is nonzero the cycle after the ack.
- The master registers `req` once and leaves IDLE two cycles later, so `m_cs` falls at issue+2. A timeout of 4 gives margin.
- `rq_done` is 1 cycle after the last required master done pulse.
- Back-to-back: the next ack is no earlier than 1 cycle after `rq_done`, and only once `m_cs`=1.
- Reset mid-transaction: return to IDLE immediately, with no done to the requester. Recovery of the master relies on it sharing `rst`.

## Structure
- Package `spi_arb_pkg`:
  - op constants `OP_NONE/OP_TX/OP_RX/OP_FD`;
  - state enum `IDLE/ISSUE/START/BUSY/DONE`;
  - `DATA_W`=12 and `WAIT_W`=8.
- Sub-module `rr_arbiter`: combinational priority rotate on the eligible vector plus pointer. Outputs are the one-hot grant and its index.

## Test plan
- Requester 0, op 01, din 0xA5C, wait 2, with a real `spi_master` → `m_req`=01 for exactly one cycle, `m_din`=0xA5C and `m_wait`=2 held, MOSI serialises 0xA5C, one `rq_done[0]`, `rq_err`=0.
- All four requesters valid continuously with op 01 → ack order 0,1,2,3,0, with no overlap of busy periods.
- Requester 2, op 11, din 0x3C1, slave returns 0xF0F, wait 5 → `rq_done[2]` only after both master done pulses, `rq_dout`=0xF0F.
- Master stub that holds `m_cs`=1 → `rq_done` with `rq_err`=1 four cycles after issue, `rq_dout` unchanged, next grant proceeds.
- Request with op 00 on requester 1 while requester 3 is valid with op 10 → requester 1 never acked; requester 3 served.
- `rst` asserted in BUSY → all outputs return to reset values the same cycle. A new request after release is served normally starting from requester 0.
